// File: rtl/frame_tx_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frame_tx_scheduler_pkg                                        |
// | Purpose  : Shared definitions for the frame transmit scheduler: frame    |
// |            width, 2-bit FSM state encodings, frame type and an index     |
// |            width helper used by the sharer and its arbiter.              |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package frame_tx_scheduler_pkg;

    // Width of one LED frame handed to the encoder.
    localparam int FRAME_SIZE = 16;

    // Scheduler FSM state encodings (legacy 2-bit values).
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    typedef logic [FRAME_SIZE-1:0] frame_t;

    // Bits needed to hold a requester index; never less than one bit so a
    // single-requester build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tx_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frame_tx_scheduler_if                                         |
// | Purpose  : Bundles the requester handshake and encoder handshake of the  |
// |            frame transmit scheduler.                                     |
// | Ports    : none; signals                                                 |
// |            req_valid/req_data  producers -> scheduler                    |
// |            req_ready/done      scheduler -> producers (1-cycle pulses)   |
// |            enc_start/enc_data  scheduler -> encoder                      |
// |            enc_irq             encoder   -> scheduler                    |
// |            busy/err            scheduler status                          |
// |            modport slave  : scheduler view                               |
// |            modport master : producer/encoder (environment) view          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface frame_tx_scheduler_if #(
    parameter int NUM_REQ = 2
);
    import frame_tx_scheduler_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FRAME_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            done;
    logic                          enc_start;
    logic [FRAME_SIZE-1:0]         enc_data;
    logic                          enc_irq;
    logic                          busy;
    logic                          err;

    modport slave (
        input  req_valid, req_data, enc_irq,
        output req_ready, done, enc_start, enc_data, busy, err
    );

    modport master (
        output req_valid, req_data, enc_irq,
        input  req_ready, done, enc_start, enc_data, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/frame_tx_scheduler_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frame_tx_scheduler_rr_arbiter                                 |
// | Purpose  : Purely combinational round-robin arbiter. Picks the first     |
// |            asserted request at or after i_ptr, wrapping to index 0.      |
// | Ports    : i_req       requests, one bit per requester                   |
// |            i_ptr       round-robin start index                           |
// |            o_grant     one-hot grant                                     |
// |            o_grant_idx binary index of the grant                         |
// |            o_any       at least one request present                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module frame_tx_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_ptr,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [IDX_W-1:0]   o_grant_idx,
    output logic                    o_any
);

    // Two ascending scans: first the indices at/after the pointer, then the
    // wrapped indices below it. Loop indices stay constant after unrolling.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && (j >= int'(i_ptr)) && i_req[j]) begin
                o_any       = 1'b1;
                o_grant[j]  = 1'b1;
                o_grant_idx = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && (j < int'(i_ptr)) && i_req[j]) begin
                o_any       = 1'b1;
                o_grant[j]  = 1'b1;
                o_grant_idx = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frame_tx_scheduler                                            |
// | Purpose  : Shares one LED encoder between NUM_REQ frame sources using    |
// |            round-robin arbitration, latches the granted frame, drives    |
// |            the encoder start/irq handshake and inserts an inter-frame    |
// |            gap of GAP_CYCLES idle cycles after every frame.              |
// | Ports    : clk    single clock, all logic on rising edge                 |
// |            reset  asynchronous, active-high                              |
// |            bus    frame_tx_scheduler_if.slave (requester + encoder side) |
// | Options  : LIGHTIO_TX_TIMEOUT_EN - when defined, S_START is abandoned    |
// |            after TIMEOUT_CYCLES without enc_irq and err pulses; when     |
// |            undefined, err is tied low and S_START waits indefinitely.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module frame_tx_scheduler
    import frame_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic           clk,
    input  wire logic           reset,
    frame_tx_scheduler_if.slave bus
);

    localparam int c_idx_w = idx_width(NUM_REQ);
    localparam int c_gap_w = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [1:0]         r_state;
    logic [c_idx_w-1:0] r_rr_ptr;
    logic [NUM_REQ-1:0] r_owner_oh;
    logic               r_enc_start;
    frame_t             r_enc_data;
    logic [NUM_REQ-1:0] r_done;
    logic [c_gap_w-1:0] r_gap;

    logic [NUM_REQ-1:0] w_grant;
    logic [c_idx_w-1:0] w_grant_idx;
    logic               w_any;
    logic [c_idx_w-1:0] w_ptr_next;
    frame_t             w_grant_data;
    logic               w_tmo_hit;

    frame_tx_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_arbiter (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // Pointer moves one past the winner so the winner becomes lowest priority.
    assign w_ptr_next = (int'(w_grant_idx) == NUM_REQ - 1) ? '0
                                                           : w_grant_idx + c_idx_w'(1);

    // One-hot grant selects the frame; an AND-OR mux avoids a variable slice.
    always_comb begin
        w_grant_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) begin
                w_grant_data = bus.req_data[j*FRAME_SIZE +: FRAME_SIZE];
            end
        end
    end

`ifdef LIGHTIO_TX_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_tmo_w-1:0] r_tmo;
    logic               r_err;

    // Fires on the TIMEOUT_CYCLES-th S_START cycle that saw no enc_irq; an
    // irq arriving on that same edge still wins in the FSM.
    assign w_tmo_hit = (r_state == S_START) && !bus.enc_irq &&
                       (r_tmo == c_tmo_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_tmo_hit;
            if ((r_state == S_START) && !bus.enc_irq && !w_tmo_hit) begin
                r_tmo <= r_tmo + c_tmo_w'(1);
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign bus.err = r_err;
`else
    logic w_unused_timeout;

    assign w_tmo_hit        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign bus.err          = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner_oh  <= '0;
            r_enc_start <= 1'b0;
            r_enc_data  <= '0;
            r_done      <= '0;
            r_gap       <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    // enc_irq is deliberately not looked at here.
                    if (w_any) begin
                        r_enc_data  <= w_grant_data;
                        r_owner_oh  <= w_grant;
                        r_rr_ptr    <= w_ptr_next;
                        r_enc_start <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    if (bus.enc_irq) begin
                        r_enc_start <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else if (w_tmo_hit) begin
                        // Abandoned frame: no done pulse, but the gap still
                        // applies before the next grant.
                        r_enc_start <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap   <= c_gap_w'(GAP_CYCLES);
                            r_state <= S_GAP;
                        end
                    end
                end
                S_DRAIN: begin
                    // The frame only counts as sent once the encoder has
                    // released irq, so a stuck-high irq cannot skip a frame.
                    if (!bus.enc_irq) begin
                        r_done <= r_owner_oh;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap   <= c_gap_w'(GAP_CYCLES);
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - c_gap_w'(1);
                    if (r_gap == c_gap_w'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Acceptance is combinational so the producer sees it in the grant cycle.
    assign bus.req_ready = (r_state == S_IDLE) ? w_grant : '0;
    assign bus.done      = r_done;
    assign bus.enc_start = r_enc_start;
    assign bus.enc_data  = r_enc_data;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_frame_tx_scheduler                                         |
// | Purpose  : Self-checking bench for frame_tx_scheduler. Three instances:  |
// |            A (GAP 16, timeout 8), B (GAP 0), C (GAP 5), each with a      |
// |            simple encoder model answering a fixed number of cycles after |
// |            enc_start.                                                    |
// | Options  : LIGHTIO_TX_TIMEOUT_EN enables the timeout scenario.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_frame_tx_scheduler;
    import frame_tx_scheduler_pkg::*;

    localparam int c_enc_len = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic [1:0] a_valid;
    frame_t     a_data0, a_data1;
    logic       a_model_en, a_irq_force, a_irq_model;
    int         a_cnt;

    frame_tx_scheduler_if #(.NUM_REQ(2)) if_a();
    assign if_a.req_valid = a_valid;
    assign if_a.req_data  = {a_data1, a_data0};
    assign if_a.enc_irq   = a_model_en ? a_irq_model : a_irq_force;

    frame_tx_scheduler #(.NUM_REQ(2), .GAP_CYCLES(16), .TIMEOUT_CYCLES(8)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_irq_model <= 1'b0; a_cnt <= 0;
        end else if (if_a.enc_start && !a_irq_model) begin
            if (a_cnt == c_enc_len - 1) begin a_irq_model <= 1'b1; a_cnt <= 0; end
            else a_cnt <= a_cnt + 1;
        end else if (!if_a.enc_start) begin
            a_irq_model <= 1'b0; a_cnt <= 0;
        end
    end

    // ---------------- instances B and C ----------------
    logic [1:0] b_valid, c_valid;
    logic       b_irq, c_irq;
    int         b_cnt, c_cnt;

    frame_tx_scheduler_if #(.NUM_REQ(2)) if_b();
    frame_tx_scheduler_if #(.NUM_REQ(2)) if_c();
    assign if_b.req_valid = b_valid;
    assign if_b.req_data  = {16'h0B0B, 16'h00B0};
    assign if_b.enc_irq   = b_irq;
    assign if_c.req_valid = c_valid;
    assign if_c.req_data  = {16'h0C0C, 16'h00C0};
    assign if_c.enc_irq   = c_irq;

    frame_tx_scheduler #(.NUM_REQ(2), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b)
    );
    frame_tx_scheduler #(.NUM_REQ(2), .GAP_CYCLES(5)) u_dut_c (
        .clk(clk), .reset(reset), .bus(if_c)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            b_irq <= 1'b0; b_cnt <= 0;
        end else if (if_b.enc_start && !b_irq) begin
            if (b_cnt == c_enc_len - 1) begin b_irq <= 1'b1; b_cnt <= 0; end
            else b_cnt <= b_cnt + 1;
        end else if (!if_b.enc_start) begin
            b_irq <= 1'b0; b_cnt <= 0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            c_irq <= 1'b0; c_cnt <= 0;
        end else if (if_c.enc_start && !c_irq) begin
            if (c_cnt == c_enc_len - 1) begin c_irq <= 1'b1; c_cnt <= 0; end
            else c_cnt <= c_cnt + 1;
        end else if (!if_c.enc_start) begin
            c_irq <= 1'b0; c_cnt <= 0;
        end
    end

    // ---------------- scoreboard and helpers ----------------
    frame_t     exp_data_q[$];
    logic [1:0] exp_done_q[$];
    int         exp_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin pick for two requesters.
    function automatic int rr_pick(input logic [1:0] v, input int p);
        for (int i = 0; i < 2; i++) begin
            if (((v >> ((p + i) % 2)) & 2'b01) != 2'b00) return (p + i) % 2;
        end
        return -1;
    endfunction

    task automatic wait_a_done(input int limit);
        for (int k = 0; k < limit && if_a.done == 2'b00; k++) @(negedge clk);
    endtask

    task automatic wait_a_idle(input int limit);
        for (int k = 0; k < limit && if_a.busy; k++) @(negedge clk);
    endtask

    function automatic logic gx_start(input int sel);
        return (sel == 0) ? if_b.enc_start : if_c.enc_start;
    endfunction
    function automatic logic [1:0] gx_done(input int sel);
        return (sel == 0) ? if_b.done : if_c.done;
    endfunction
    function automatic logic gx_busy(input int sel);
        return (sel == 0) ? if_b.busy : if_c.busy;
    endfunction
    task automatic gx_valid(input int sel, input logic [1:0] v);
        if (sel == 0) b_valid = v; else c_valid = v;
    endtask

    // Back-to-back frames from requester 0; counts cycles from the done
    // pulse of the first frame to enc_start of the second.
    task automatic gap_test(input int sel, input int exp_n, input string tag);
        int n;
        gx_valid(sel, 2'b01);
        for (int k = 0; k < 100 && gx_done(sel) == 2'b00; k++) @(negedge clk);
        check({tag, "_done"}, gx_done(sel), 2'b01);
        n = 0;
        while (!gx_start(sel) && n < 50) begin @(negedge clk); n++; end
        check(tag, n, exp_n);
        gx_valid(sel, 2'b00);
        for (int k = 0; k < 100 && gx_busy(sel); k++) @(negedge clk);
        check({tag, "_idle"}, gx_busy(sel), 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, g, prev_cyc;
        logic saw_done;

        a_valid = 2'b00; a_data0 = '0; a_data1 = '0;
        a_model_en = 1'b1; a_irq_force = 1'b0;
        b_valid = 2'b00; c_valid = 2'b00;
        exp_ptr = 0; prev_cyc = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", if_a.busy, 1'b0);
        check("rst_start", if_a.enc_start, 1'b0);
        check("rst_data", if_a.enc_data, 16'h0000);
        check("rst_ready", if_a.req_ready, 2'b00);
        check("rst_done", if_a.done, 2'b00);
        check("rst_err", if_a.err, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Single frame from requester 0
        a_data0 = 16'h5555; a_valid = 2'b01;
        exp_data_q.push_back(16'h5555); exp_done_q.push_back(2'b01);
        #1;
        check("sf_ready", if_a.req_ready, 2'b01);
        exp_ptr = 1;
        @(negedge clk);
        check("sf_ready_pulse", if_a.req_ready, 2'b00);
        a_valid = 2'b00;
        check("sf_start", if_a.enc_start, 1'b1);
        check("sf_data", if_a.enc_data, exp_data_q.pop_front());
        check("sf_busy", if_a.busy, 1'b1);
        wait_a_done(100);
        check("sf_done", if_a.done, exp_done_q.pop_front());
        @(negedge clk);
        check("sf_done_pulse", if_a.done, 2'b00);
        n = 1;
        while (if_a.busy && n < 100) begin @(negedge clk); n++; end
        check("sf_gap", n, 16);

        // Contention: both requesters held valid
        a_data0 = 16'hA0A0; a_data1 = 16'h0B0B; a_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            n = 0;
            while (if_a.req_ready == 2'b00 && n < 300) begin @(negedge clk); #1; n++; end
            g = rr_pick(2'b11, exp_ptr);
            exp_data_q.push_back((g == 0) ? 16'hA0A0 : 16'h0B0B);
            exp_done_q.push_back(2'b01 << g);
            check("ct_grant", if_a.req_ready, 2'b01 << g);
            if (i > 0) check("ct_spacing", (cyc - prev_cyc) >= 19, 1'b1);
            prev_cyc = cyc;
            exp_ptr = (g + 1) % 2;
            @(negedge clk);
            if (i == 3) a_valid = 2'b00;
            check("ct_start", if_a.enc_start, 1'b1);
            check("ct_data", if_a.enc_data, exp_data_q.pop_front());
            wait_a_done(100);
            check("ct_done", if_a.done, exp_done_q.pop_front());
            @(negedge clk);
        end
        wait_a_idle(100);
        check("ct_idle", if_a.busy, 1'b0);

        // Inter-frame gap on instances B (0) and C (5)
        gap_test(0, 1, "gap0");
        gap_test(1, 6, "gap5");

        // Early irq: encoder irq already high before the grant
        a_model_en = 1'b0; a_irq_force = 1'b1;
        repeat (2) @(negedge clk);
        check("ei_idle", if_a.busy, 1'b0);
        a_data1 = 16'hC3C3; a_valid = 2'b10;
        g = rr_pick(2'b10, exp_ptr);
        exp_data_q.push_back(16'hC3C3); exp_done_q.push_back(2'b01 << g);
        exp_ptr = (g + 1) % 2;
        #1;
        check("ei_ready", if_a.req_ready, 2'b10);
        @(negedge clk);
        a_valid = 2'b00;
        check("ei_start", if_a.enc_start, 1'b1);
        check("ei_data", if_a.enc_data, exp_data_q.pop_front());
        @(negedge clk);
        check("ei_exit", {if_a.enc_start, if_a.busy}, 2'b01);
        saw_done = 1'b0;
        repeat (3) begin @(negedge clk); saw_done = saw_done | (|if_a.done); end
        check("ei_hold", saw_done, 1'b0);
        a_irq_force = 1'b0;
        @(negedge clk);
        check("ei_done", if_a.done, exp_done_q.pop_front());
        a_model_en = 1'b1;
        wait_a_idle(100);

        // Reset mid-frame
        a_data0 = 16'h1234; a_valid = 2'b01;
        #1;
        check("rm_ready", if_a.req_ready, 2'b01);
        @(negedge clk);
        a_valid = 2'b00;
        check("rm_start_hi", if_a.enc_start, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rm_start", if_a.enc_start, 1'b0);
        check("rm_busy", if_a.busy, 1'b0);
        check("rm_data", if_a.enc_data, 16'h0000);
        exp_ptr = 0;
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin @(negedge clk); saw_done = saw_done | (|if_a.done); end
        check("rm_nodone", saw_done, 1'b0);
        a_data1 = 16'h4321; a_valid = 2'b11;
        #1;
        check("rm_ptr", if_a.req_ready, 2'b01 << rr_pick(2'b11, exp_ptr));
        exp_ptr = 1;
        @(negedge clk);
        a_valid = 2'b00;
        check("rm_data2", if_a.enc_data, 16'h1234);
        wait_a_done(100);
        check("rm_done", if_a.done, 2'b01);
        wait_a_idle(100);

`ifdef LIGHTIO_TX_TIMEOUT_EN
        // Encoder never answers
        a_model_en = 1'b0; a_irq_force = 1'b0;
        a_valid = 2'b10;
        #1;
        check("to_ready", if_a.req_ready, 2'b01 << rr_pick(2'b10, exp_ptr));
        exp_ptr = 0;
        @(negedge clk);
        a_valid = 2'b00;
        saw_done = 1'b0;
        n = 0;
        while (!if_a.err && n < 50) begin @(negedge clk); saw_done = saw_done | (|if_a.done); n++; end
        check("to_cycles", n, 8);
        check("to_start", if_a.enc_start, 1'b0);
        @(negedge clk);
        check("to_err_pulse", if_a.err, 1'b0);
        a_model_en = 1'b1;
        wait_a_idle(100);
        check("to_nodone", saw_done | (|if_a.done), 1'b0);
        a_valid = 2'b01;
        #1;
        check("to_next", if_a.req_ready, 2'b01);
        @(negedge clk);
        a_valid = 2'b00;
        wait_a_done(100);
        check("to_next_done", if_a.done, 2'b01);
        wait_a_idle(100);
`else
        check("err_low", if_a.err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
